// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, with false-start rejection,
// framing-error and overrun reporting, and a valid/ready byte output.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          armed_q, armed_d;
  logic          sync1_q, rx_s_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Next-state, bit sampling and output-event logic for the receive FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;
    if (valid_q && rx_ready) valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // The line must be seen high before a falling edge counts as a start.
        if (rx_s_q) armed_d = 1'b1;
        else if (armed_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          bit_d          = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            // A byte that is accepted on this same edge is not an overrun.
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx_ready;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_overrun = ovr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a timing-offset model
// of the receiver, compared on every clock.
module tb_uart_rx;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 5_000_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic       m_s1 = 1'b1, m_s = 1'b1;
  logic       m_armed = 1'b0, m_busy = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_data = 8'h00, m_bits = 8'h00;
  int         m_e0 = 0;
  int         m_k;
  logic       s_old, v_old, a_old;

  // Receiver model: a frame is described by its start edge E0; every
  // sample happens at a fixed offset HALF + n*CPB from it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s = 1'b1; m_armed = 1'b0; m_busy = 1'b0; m_valid = 1'b0;
      m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h00; m_bits = 8'h00;
    end else begin
      s_old = m_s; v_old = m_valid; a_old = m_armed;
      m_ovr = 1'b0; m_ferr = 1'b0;
      if (v_old && rx_ready) m_valid = 1'b0;
      if (!m_busy) begin
        if (s_old) m_armed = 1'b1;
        else if (a_old) begin m_busy = 1'b1; m_e0 = cyc; end
      end else begin
        m_k = cyc - m_e0;
        if (m_k == HALF) begin
          if (s_old) m_busy = 1'b0;
        end else if (m_k > HALF && (m_k - HALF) % CPB == 0) begin
          if ((m_k - HALF) / CPB <= 8) begin
            m_bits[3'((m_k - HALF) / CPB - 1)] = s_old;
          end else begin
            m_busy = 1'b0;
            if (s_old) begin
              m_ovr   = v_old && !rx_ready;
              m_data  = m_bits;
              m_valid = 1'b1;
            end else begin
              m_ferr  = 1'b1;
              m_armed = 1'b0;
            end
          end
        end
      end
      m_s  = m_s1;
      m_s1 = rx;
    end
  end

  // Bench-side stimulus/monitor state (all owned by the main process)
  logic       chk_en = 1'b0, rand_ready = 1'b0, ready_cmd = 1'b0;
  int         pulse_cyc = -1;
  logic       prev_valid = 1'b0, prev_busy = 1'b0;
  int         valid_rise = -1, busy_rise = -1, busy_fall = -1;
  int         n_ovr = 0, n_ferr = 0, n_busy_rise = 0;
  logic [7:0] rcv_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare and monitor on the falling edge, then drive rx_ready after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en)
      check("outputs{data,valid,ovr,ferr,busy}",
            {20'h0, rx_data, rx_valid, rx_overrun, frame_err, rx_busy},
            {20'h0, m_data, m_valid, m_ovr, m_ferr, m_busy});
    if (rx_valid && !prev_valid) begin valid_rise = cyc; rcv_q.push_back(rx_data); end
    if (rx_overrun) n_ovr++;
    if (frame_err) n_ferr++;
    if (rx_busy && !prev_busy) begin busy_rise = cyc; n_busy_rise++; end
    if (!rx_busy && prev_busy) busy_fall = cyc;
    prev_valid = rx_valid;
    prev_busy  = rx_busy;
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    else            rx_ready = ready_cmd || (cyc == pulse_cyc);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int bl);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      ticks(bl);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'h0, rx_data}, 32'h00);
    check({tag, "_valid"}, {31'h0, rx_valid}, 32'h0);
    check({tag, "_ovr"},   {31'h0, rx_overrun}, 32'h0);
    check({tag, "_ferr"},  {31'h0, frame_err}, 32'h0);
    check({tag, "_busy"},  {31'h0, rx_busy}, 32'h0);
  endtask

  initial begin
    int c0;
    logic [9:0] f;
    logic [7:0] b;
    rx = 1'b1; rst_n = 1'b0; rx_ready = 1'b0;
    #1;
    ticks(3);
    check_reset_outputs("reset");
    chk_en = 1'b1;
    rst_n  = 1'b1;
    ticks(10);

    // 0xA5, consumer not ready
    c0 = cyc;
    send(8'hA5, 1'b1, CPB);
    check("a5_data", {24'h0, rx_data}, 32'hA5);
    check("a5_model_data", {24'h0, m_data}, 32'hA5);
    check("a5_valid", {31'h0, rx_valid}, 32'h1);
    check("a5_valid_latency", valid_rise - c0, 98);
    check("a5_ferr_count", n_ferr, 0);
    ready_cmd = 1'b1;
    tick();
    ready_cmd = 1'b0;
    tick();
    check("a5_valid_cleared", {31'h0, rx_valid}, 32'h0);
    ticks(5);

    // Back-to-back with ready tied high
    ready_cmd = 1'b1;
    ticks(2);
    rcv_q.delete();
    n_ovr = 0;
    send(8'h00, 1'b1, CPB);
    send(8'hFF, 1'b1, CPB);
    send(8'h3C, 1'b1, CPB);
    ticks(3);
    check("b2b_count", rcv_q.size(), 3);
    if (rcv_q.size() == 3) begin
      check("b2b_byte0", {24'h0, rcv_q[0]}, 32'h00);
      check("b2b_byte1", {24'h0, rcv_q[1]}, 32'hFF);
      check("b2b_byte2", {24'h0, rcv_q[2]}, 32'h3C);
    end
    check("b2b_overrun", n_ovr, 0);
    ready_cmd = 1'b0;
    ticks(5);

    // Overrun: two bytes without consuming
    n_ovr = 0;
    send(8'h11, 1'b1, CPB);
    send(8'h22, 1'b1, CPB);
    check("ovr_count", n_ovr, 1);
    check("ovr_data", {24'h0, rx_data}, 32'h22);
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    ready_cmd = 1'b1;
    tick();
    ready_cmd = 1'b0;
    ticks(3);

    // Same pair, consumer accepts exactly on the second stop-sample edge
    n_ovr = 0;
    send(8'h11, 1'b1, CPB);
    c0 = cyc;
    pulse_cyc = c0 + 97;
    send(8'h22, 1'b1, CPB);
    pulse_cyc = -1;
    check("noovr_count", n_ovr, 0);
    check("noovr_data", {24'h0, rx_data}, 32'h22);
    check("noovr_valid", {31'h0, rx_valid}, 32'h1);
    ready_cmd = 1'b1;
    tick();
    ready_cmd = 1'b0;
    ticks(3);

    // Framing error, then a 30-bit break, then a good byte
    n_ferr = 0;
    rcv_q.delete();
    send(8'h55, 1'b0, CPB);
    check("ferr_count", n_ferr, 1);
    check("ferr_valid", {31'h0, rx_valid}, 32'h0);
    n_busy_rise = 0;
    rx = 1'b0;
    ticks(30 * CPB);
    check("break_no_start", n_busy_rise, 0);
    rx = 1'b1;
    ticks(2 * CPB);
    send(8'h7E, 1'b1, CPB);
    check("after_break_data", {24'h0, rx_data}, 32'h7E);
    check("after_break_valid", {31'h0, rx_valid}, 32'h1);
    check("after_break_ferr", n_ferr, 1);

    // 3-cycle glitch on the idle line
    n_ovr = 0; n_ferr = 0;
    c0 = cyc;
    rx = 1'b0;
    ticks(3);
    rx = 1'b1;
    ticks(2 * CPB);
    check("glitch_e0", busy_rise - c0, 3);
    check("glitch_busy_len", busy_fall - busy_rise, HALF);
    check("glitch_flags", n_ovr + n_ferr, 0);
    check("glitch_data_kept", {24'h0, rx_data}, 32'h7E);

    // Reset in the middle of 0x99
    f = {1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = f[i];
      ticks(CPB);
    end
    rx = f[5];
    rst_n = 1'b0;
    ticks(3);
    check_reset_outputs("midreset");
    rx = 1'b1;
    rst_n = 1'b1;
    ticks(2 * CPB);
    send(8'h42, 1'b1, CPB);
    check("post_reset_data", {24'h0, rx_data}, 32'h42);
    check("post_reset_valid", {31'h0, rx_valid}, 32'h1);

    // Randomized traffic with random consumer, stop bits and bit length
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      send(b, ($urandom_range(0, 9) != 0), $urandom_range(CPB - 1, CPB + 1));
      rx = 1'b1;
      ticks($urandom_range(1, 12));
    end
    rand_ready = 1'b0;
    ticks(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
